// File: rtl/dcache_mshr_ctrl_pkg.sv
// Shared dcache definitions: MSHR entry states, default geometry and address/robid widths.
package dcache_mshr_ctrl_pkg;

    localparam int MSHR_NUM_DEF    = 4;
    localparam int LINE_OFFSET_DEF = 6;
    localparam int PADDR_WIDTH     = 40;
    localparam int ROB_SIZE_LOG    = 6;
    localparam int ROBID_WIDTH     = ROB_SIZE_LOG + 1;

    typedef enum logic [1:0] {
        MSHR_IDLE       = 2'd0,
        MSHR_WAIT_ISSUE = 2'd1,
        MSHR_WAIT_RESP  = 2'd2,
        MSHR_WAKEUP     = 2'd3
    } mshr_state_e;

endpackage

// File: rtl/dcache_mshr_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a pointer that moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] scan_idx;
    logic          found;

    // N is a power of two, so the IW-bit add wraps around the entry ring.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = ptr_q + IW'(i);
            if (!found && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr_q <= IW'(i) + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// Dcache miss status holding registers: allocate on load miss, issue refills, wake the owning ROB entry.
module dcache_mshr_ctrl
    import dcache_mshr_ctrl_pkg::*;
#(
    parameter int MSHR_NUM    = MSHR_NUM_DEF,
    parameter int LINE_OFFSET = LINE_OFFSET_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [PADDR_WIDTH-1:0]      alloc_paddr,
    input  logic [ROBID_WIDTH-1:0]      alloc_robid,
    output logic                        refill_req_valid,
    input  logic                        refill_req_ready,
    output logic [PADDR_WIDTH-1:0]      refill_req_paddr,
    output logic [$clog2(MSHR_NUM)-1:0] refill_req_id,
    input  logic                        refill_resp_valid,
    input  logic [$clog2(MSHR_NUM)-1:0] refill_resp_id,
    output logic                        wakeup_valid,
    output logic [ROBID_WIDTH-1:0]      wakeup_robid,
    output logic [2*MSHR_NUM-1:0]       mshr_state_dbg
);

    localparam int ID_W   = $clog2(MSHR_NUM);
    localparam int LINE_W = PADDR_WIDTH - LINE_OFFSET;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high at the
    // rising edge; once raised, refill_req_valid with its paddr/id stays put until ready.
    // wakeup has no ready and is consumed whenever valid.

    mshr_state_e            state_q [MSHR_NUM];
    logic [LINE_W-1:0]      line_q  [MSHR_NUM];
    logic [ROBID_WIDTH-1:0] robid_q [MSHR_NUM];
    logic [MSHR_NUM-1:0]    killed_q;
    logic                   hold_q;
    logic [ID_W-1:0]        hold_id_q;

    logic [LINE_W-1:0]   alloc_line;
    logic                alloc_offset_unused;
    logic [MSHR_NUM-1:0] idle_vec;
    logic [MSHR_NUM-1:0] issue_vec;
    logic [MSHR_NUM-1:0] wake_vec;
    logic [MSHR_NUM-1:0] line_hit_vec;
    logic [ID_W-1:0]     alloc_sel;
    logic                alloc_fire;
    logic [MSHR_NUM-1:0] hold_onehot;
    logic [MSHR_NUM-1:0] issue_req;
    logic [MSHR_NUM-1:0] issue_grant;
    logic [ID_W-1:0]     issue_id;
    logic                issue_fire;
    logic [MSHR_NUM-1:0] wake_grant;
    logic [ID_W-1:0]     wake_id;

    assign alloc_line          = alloc_paddr[PADDR_WIDTH-1:LINE_OFFSET];
    assign alloc_offset_unused = ^alloc_paddr[LINE_OFFSET-1:0];

    always_comb begin
        idle_vec       = '0;
        issue_vec      = '0;
        wake_vec       = '0;
        line_hit_vec   = '0;
        mshr_state_dbg = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            idle_vec[i]            = (state_q[i] == MSHR_IDLE);
            issue_vec[i]           = (state_q[i] == MSHR_WAIT_ISSUE);
            wake_vec[i]            = (state_q[i] == MSHR_WAKEUP);
            line_hit_vec[i]        = (state_q[i] != MSHR_IDLE) && (line_q[i] == alloc_line);
            mshr_state_dbg[2*i +: 2] = state_q[i];
        end
    end

    always_comb begin
        alloc_sel = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (idle_vec[i]) begin
                alloc_sel = ID_W'(i);
            end
        end
    end

    // Only registered state feeds readiness, so an entry freed this cycle is reusable next cycle.
    assign alloc_ready = !reset && !flush && (|idle_vec) && !(|line_hit_vec);
    assign alloc_fire  = alloc_valid && alloc_ready;

    // A stalled request pins the arbiter to the same entry so paddr/id cannot change under it.
    assign hold_onehot = {{(MSHR_NUM-1){1'b0}}, 1'b1} << hold_id_q;
    assign issue_req   = hold_q ? hold_onehot : issue_vec;

    rr_arbiter #(.N(MSHR_NUM)) u_issue_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (issue_req),
        .advance (issue_fire),
        .grant   (issue_grant)
    );

    rr_arbiter #(.N(MSHR_NUM)) u_wake_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (wake_vec),
        .advance (wakeup_valid),
        .grant   (wake_grant)
    );

    always_comb begin
        issue_id = '0;
        wake_id  = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            if (issue_grant[i]) begin
                issue_id = issue_id | ID_W'(i);
            end
            if (wake_grant[i]) begin
                wake_id = wake_id | ID_W'(i);
            end
        end
    end

    assign refill_req_valid = !reset && (|issue_grant);
    assign refill_req_id    = issue_id;
    assign refill_req_paddr = {line_q[issue_id], {LINE_OFFSET{1'b0}}};
    assign issue_fire       = refill_req_valid && refill_req_ready;

    assign wakeup_valid = !reset && !flush && (|wake_grant);
    assign wakeup_robid = robid_q[wake_id];

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q    <= 1'b0;
            hold_id_q <= '0;
            killed_q  <= '0;
            for (int i = 0; i < MSHR_NUM; i++) begin
                state_q[i] <= MSHR_IDLE;
                line_q[i]  <= '0;
                robid_q[i] <= '0;
            end
        end else begin
            hold_q    <= refill_req_valid && !refill_req_ready && !flush;
            hold_id_q <= issue_id;
            for (int i = 0; i < MSHR_NUM; i++) begin
                case (state_q[i])
                    MSHR_IDLE: begin
                        if (alloc_fire && (alloc_sel == ID_W'(i))) begin
                            state_q[i]  <= MSHR_WAIT_ISSUE;
                            line_q[i]   <= alloc_line;
                            robid_q[i]  <= alloc_robid;
                            killed_q[i] <= 1'b0;
                        end
                    end
                    MSHR_WAIT_ISSUE: begin
                        // A request that went out in the flush cycle still owes a response.
                        if (issue_fire && (issue_id == ID_W'(i))) begin
                            state_q[i]  <= MSHR_WAIT_RESP;
                            killed_q[i] <= flush;
                        end else if (flush) begin
                            state_q[i] <= MSHR_IDLE;
                        end
                    end
                    MSHR_WAIT_RESP: begin
                        if (refill_resp_valid && (refill_resp_id == ID_W'(i))) begin
                            state_q[i]  <= (killed_q[i] || flush) ? MSHR_IDLE : MSHR_WAKEUP;
                            killed_q[i] <= 1'b0;
                        end else if (flush) begin
                            killed_q[i] <= 1'b1;
                        end
                    end
                    MSHR_WAKEUP: begin
                        if (flush || (wakeup_valid && wake_grant[i])) begin
                            state_q[i] <= MSHR_IDLE;
                        end
                    end
                    default: state_q[i] <= MSHR_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed bench for dcache_mshr_ctrl: driver tasks push expected refills/wakeups, a negedge monitor checks them.
module tb_dcache_mshr_ctrl;
    import dcache_mshr_ctrl_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int PW   = PADDR_WIDTH;
    localparam int RW   = ROBID_WIDTH;

    logic            clock;
    logic            reset;
    logic            flush;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [PW-1:0]   alloc_paddr;
    logic [RW-1:0]   alloc_robid;
    logic            refill_req_valid;
    logic            refill_req_ready;
    logic [PW-1:0]   refill_req_paddr;
    logic [ID_W-1:0] refill_req_id;
    logic            refill_resp_valid;
    logic [ID_W-1:0] refill_resp_id;
    logic            wakeup_valid;
    logic [RW-1:0]   wakeup_robid;
    logic [2*N-1:0]  mshr_state_dbg;

    dcache_mshr_ctrl #(.MSHR_NUM(N), .LINE_OFFSET(6)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_paddr       (alloc_paddr),
        .alloc_robid       (alloc_robid),
        .refill_req_valid  (refill_req_valid),
        .refill_req_ready  (refill_req_ready),
        .refill_req_paddr  (refill_req_paddr),
        .refill_req_id     (refill_req_id),
        .refill_resp_valid (refill_resp_valid),
        .refill_resp_id    (refill_resp_id),
        .wakeup_valid      (wakeup_valid),
        .wakeup_robid      (wakeup_robid),
        .mshr_state_dbg    (mshr_state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;
    logic [PW+ID_W-1:0] exp_req_q[$];
    logic [RW-1:0]      exp_wake_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        flush             = 1'b0;
        alloc_valid       = 1'b0;
        refill_resp_valid = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            check("rst_alloc_ready", alloc_ready, 0);
            check("rst_refill_valid", refill_req_valid, 0);
            check("rst_wakeup_valid", wakeup_valid, 0);
            tick(1);
        end
        reset = 1'b0;
        #1;
        check("post_rst_alloc_ready", alloc_ready, 1);
        check("post_rst_all_idle", mshr_state_dbg, 8'h00);
    endtask

    task automatic alloc(input logic [PW-1:0] pa, input logic [RW-1:0] rid, input bit exp_ready,
                         input string name);
        alloc_valid = 1'b1;
        alloc_paddr = pa;
        alloc_robid = rid;
        #1;
        check(name, alloc_ready, exp_ready);
        tick(1);
        alloc_valid = 1'b0;
    endtask

    task automatic resp(input logic [ID_W-1:0] id);
        refill_resp_valid = 1'b1;
        refill_resp_id    = id;
        tick(1);
        refill_resp_valid = 1'b0;
    endtask

    // scoreboard monitor
    logic            prev_stall = 1'b0;
    logic [PW-1:0]   prev_paddr;
    logic [ID_W-1:0] prev_id;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && refill_req_valid) begin
                check("stall_paddr_stable", refill_req_paddr, prev_paddr);
                check("stall_id_stable", refill_req_id, prev_id);
            end
            if (refill_req_valid && refill_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL refill_unexpected actual=%0h/%0d required=none",
                             refill_req_paddr, refill_req_id);
                end else begin
                    check("refill_req", {refill_req_paddr, refill_req_id}, exp_req_q.pop_front());
                end
            end
            if (wakeup_valid) begin
                if (exp_wake_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wakeup_unexpected actual=%0d required=none", wakeup_robid);
                end else begin
                    check("wakeup_robid", wakeup_robid, exp_wake_q.pop_front());
                end
            end
            prev_stall = refill_req_valid && !refill_req_ready;
            prev_paddr = refill_req_paddr;
            prev_id    = refill_req_id;
        end
    end

    initial begin
        alloc_paddr      = '0;
        alloc_robid      = '0;
        refill_resp_id   = '0;
        refill_req_ready = 1'b1;
        do_reset();

        // single miss
        exp_req_q.push_back({40'h00_1000_0040, 2'd0});
        exp_wake_q.push_back(7'd5);
        alloc(40'h00_1000_0040, 7'd5, 1, "single_alloc_ready");
        tick(1);
        resp(2'd0);
        check("single_wake_latency", wakeup_valid, 1);
        tick(2);

        // full: four distinct lines, fifth stalls, free reopens
        for (int i = 0; i < 4; i++) begin
            exp_req_q.push_back({40'h00_3000_0000 + 40'(i * 64), ID_W'(i)});
        end
        for (int i = 0; i < 4; i++) begin
            alloc(40'h00_3000_0000 + 40'(i * 64), RW'(i + 1), 1, "full_alloc_ready");
        end
        alloc(40'h00_3000_0100, 7'd6, 0, "full_fifth_blocked");
        exp_wake_q.push_back(7'd3);
        resp(2'd2);
        check("full_wakeup_busy", alloc_ready, 0);
        tick(1);
        check("full_after_free", alloc_ready, 1);
        exp_req_q.push_back({40'h00_3000_0100, 2'd2});
        alloc(40'h00_3000_0100, 7'd6, 1, "full_realloc_ready");
        tick(1);
        exp_wake_q.push_back(7'd1);
        exp_wake_q.push_back(7'd2);
        exp_wake_q.push_back(7'd4);
        exp_wake_q.push_back(7'd6);
        resp(2'd0);
        resp(2'd1);
        resp(2'd3);
        resp(2'd2);
        tick(2);

        // same line stalls until the first entry is idle
        exp_req_q.push_back({40'h00_2000_0000, 2'd0});
        exp_wake_q.push_back(7'd7);
        exp_req_q.push_back({40'h00_2000_0000, 2'd0});
        exp_wake_q.push_back(7'd8);
        alloc(40'h00_2000_0000, 7'd7, 1, "same_first_ready");
        alloc_valid = 1'b1;
        alloc_paddr = 40'h00_2000_0020;
        alloc_robid = 7'd8;
        #1;
        check("same_line_issue", alloc_ready, 0);
        tick(1);
        check("same_line_wait_resp", alloc_ready, 0);
        refill_resp_valid = 1'b1;
        refill_resp_id    = 2'd0;
        tick(1);
        refill_resp_valid = 1'b0;
        check("same_line_wakeup", alloc_ready, 0);
        tick(1);
        check("same_line_free", alloc_ready, 1);
        tick(1);
        alloc_valid = 1'b0;
        tick(1);
        resp(2'd0);
        tick(2);

        // backpressure with three pending, grants in index order
        do_reset();
        refill_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back({40'h00_4000_0000 + 40'(i * 64), ID_W'(i)});
        end
        for (int i = 0; i < 3; i++) begin
            alloc(40'h00_4000_0000 + 40'(i * 64), RW'(9 + i), 1, "bp_alloc_ready");
        end
        tick(1);
        check("bp_valid", refill_req_valid, 1);
        check("bp_id", refill_req_id, 0);
        check("bp_paddr", refill_req_paddr, 40'h00_4000_0000);
        refill_req_ready = 1'b1;
        tick(3);
        exp_wake_q.push_back(7'd9);
        exp_wake_q.push_back(7'd10);
        exp_wake_q.push_back(7'd11);
        resp(2'd0);
        resp(2'd1);
        resp(2'd2);
        tick(2);

        // flush with entry 0 in WAIT_RESP and entry 1 in WAIT_ISSUE
        exp_req_q.push_back({40'h00_5000_0000, 2'd0});
        alloc(40'h00_5000_0000, 7'd12, 1, "flush_alloc0_ready");
        tick(1);
        refill_req_ready = 1'b0;
        alloc(40'h00_5000_0040, 7'd13, 1, "flush_alloc1_ready");
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_paddr = 40'h00_5000_0080;
        alloc_robid = 7'd14;
        #1;
        check("flush_alloc_block", alloc_ready, 0);
        check("flush_no_wake", wakeup_valid, 0);
        tick(1);
        flush       = 1'b0;
        alloc_valid = 1'b0;
        check("flush_drop_req", refill_req_valid, 0);
        check("flush_state", mshr_state_dbg, 8'h02);
        refill_req_ready = 1'b1;
        tick(2);
        resp(2'd0);
        tick(2);
        check("flush_all_idle", mshr_state_dbg, 8'h00);

        // reset with three live entries, then a stale response
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back({40'h00_6000_0000 + 40'(i * 64), ID_W'(i)});
        end
        for (int i = 0; i < 3; i++) begin
            alloc(40'h00_6000_0000 + 40'(i * 64), RW'(14 + i), 1, "mid_alloc_ready");
        end
        tick(1);
        check("mid_live_state", mshr_state_dbg, 8'h2A);
        do_reset();
        resp(2'd1);
        check("stale_resp_no_wake", wakeup_valid, 0);
        tick(2);
        check("stale_all_idle", mshr_state_dbg, 8'h00);

        check("req_queue_drained", 64'(exp_req_q.size()), 0);
        check("wake_queue_drained", 64'(exp_wake_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_mshr_ctrl.md
DCACHE_MSHR_CTRL -- requirements
Module: dcache_mshr_ctrl

Interface
- REQ-001 SHALL have parameter MSHR_NUM, default 4, giving the number of miss entries (power of two, at least 2).
- REQ-002 SHALL have parameter LINE_OFFSET, default 6, giving the low paddr bits dropped for line address (64 B line).
- REQ-003 SHALL have port clock, input, 1, the single clock.
- REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port flush, input, 1, kills all speculative misses.
- REQ-006 SHALL have ports alloc_valid (input, 1) and alloc_ready (output, 1), the allocate handshake from the load pipe miss path.
- REQ-007 SHALL have ports alloc_paddr (input, `PADDR_RANGE) and alloc_robid (input, `ROB_SIZE_LOG+1), the miss address and owner.
- REQ-008 SHALL have ports refill_req_valid (output, 1) and refill_req_ready (input, 1), the refill request handshake to the next level.
- REQ-009 SHALL have ports refill_req_paddr (output, `PADDR_RANGE, low LINE_OFFSET bits zero) and refill_req_id (output, log2(MSHR_NUM)).
- REQ-010 SHALL have ports refill_resp_valid (input, 1) and refill_resp_id (input, log2(MSHR_NUM)), the refill completion.
- REQ-011 SHALL have ports wakeup_valid (output, 1) and wakeup_robid (output, `ROB_SIZE_LOG+1), the replay wakeup (no ready; always consumed).

Function
- REQ-012 SHALL keep per entry: state {IDLE, WAIT_ISSUE, WAIT_RESP, WAKEUP}, line address, robid, killed bit.
- REQ-013 SHALL assert alloc_ready iff, from registered state only, some entry is IDLE, no live entry holds the same line address, and flush is low.
- REQ-014 SHALL, on alloc_valid&alloc_ready in cycle N, load the lowest-index IDLE entry so it is WAIT_ISSUE in N+1.
- REQ-015 SHALL select among WAIT_ISSUE entries round-robin; refill_req_valid SHALL be asserted in N+1 at the earliest after allocation.
- REQ-016 SHALL hold the issued entry's paddr and id stable while refill_req_valid&!refill_req_ready.
- REQ-017 SHALL advance the round-robin pointer past the granted entry only on a refill handshake; on handshake the entry SHALL go WAIT_RESP.
- REQ-018 SHALL, on refill_resp_valid for an entry in WAIT_RESP, move it to WAKEUP, or to IDLE if its killed bit is set.
- REQ-019 SHALL ignore refill_resp_valid whose id names an entry not in WAIT_RESP.
- REQ-020 SHALL emit one wakeup per cycle, choosing among WAKEUP entries round-robin on an independent pointer, then return that entry to IDLE.
- REQ-021 SHALL drive wakeup_valid in M+1 at the earliest after a response in cycle M.
- REQ-022 SHALL, on flush, return WAIT_ISSUE and WAKEUP entries to IDLE and set killed on WAIT_RESP entries.
- REQ-023 SHALL, on flush, drop any refill request not handshaken that cycle and suppress wakeup_valid that cycle.
- REQ-024 SHALL give flush priority over a same-cycle allocate; no entry is allocated.
- REQ-025 SHALL not let an entry freed in cycle N be allocated before N+1.

Reset
- REQ-026 SHALL, on reset high at a clock edge, set all entries IDLE, clear killed bits, and zero both round-robin pointers.
- REQ-027 SHALL hold alloc_ready=0, refill_req_valid=0 and wakeup_valid=0 during reset; alloc_ready=1 the cycle after reset deasserts.
- REQ-028 SHALL discard in-flight entries on reset mid-operation; later stale responses are ignored per REQ-019.

Structure
- REQ-029 SHALL place the MSHR state enum and the MSHR_NUM/LINE_OFFSET defaults in the shared dcache package.
- REQ-030 SHALL instantiate sub-module rr_arbiter (request vector, advance enable, one-hot grant) twice: issue and wakeup.

Verification
- REQ-031 SHALL cover single miss: alloc 0x1000_0040 robid 5, ready tied 1, resp id 0 two cycles later -> one refill req paddr 0x1000_0040 id 0, wakeup robid 5 one cycle after resp.
- REQ-032 SHALL cover full: 4 distinct-line allocs, no resp -> alloc_ready=0 on the 5th; a resp plus wakeup frees an entry, and alloc_ready=1 the cycle after the free.
- REQ-033 SHALL cover same line: alloc 0x2000_0000 then 0x2000_0020 -> second stalled (alloc_ready=0) until the first entry returns IDLE.
- REQ-034 SHALL cover backpressure and ordering: refill_req_ready=0 for 3 cycles with entries 0..2 pending -> paddr/id stable, then grants in order 0, 1, 2.
- REQ-035 SHALL cover flush: flush with entry 0 WAIT_RESP and entry 1 WAIT_ISSUE -> entry 1 never issued, resp id 0 produces no wakeup, all entries IDLE afterward.
- REQ-036 SHALL cover reset mid-operation: reset with 3 live entries -> all outputs 0 during reset; stale resp id 1 afterward produces no wakeup.
